// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte sources. Requester 0 is the
// core's output path and requester 1 is a debug/boot monitor. In IDLE one
// pending byte is accepted and captured. The transmitter is then driven
// through start -> busy -> done. A watchdog aborts the frame if the
// transmitter never raises tx_busy after tx_start.
//
// Build option:
//   UART_ARB_RR_EN  defined   : round-robin tie break. The requester not
//                               granted last wins a tie.
//   UART_ARB_RR_EN  undefined : fixed priority. Requester 0 wins every tie.
//
// Parameters:
//   BUSY_TIMEOUT  cycles to wait in WAIT_BUSY for tx_busy (legal 1..255)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   valid0/1     requester has a byte
//   data0/1      requester byte
//   ready0/1     byte accepted this cycle (combinational, IDLE only)
//   tx_start     one-cycle start pulse to the transmitter (registered)
//   tx_data      byte in flight, held from tx_start until back in IDLE
//   tx_busy      transmitter is shifting a frame
//   grant        index of the requester owning the byte in flight
//   busy         high whenever the arbiter is not in IDLE
//   err_timeout  one-cycle pulse when the busy watchdog aborts a frame
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0,
    input  logic [7:0] data0,
    output logic       ready0,
    input  logic       valid1,
    input  logic [7:0] data1,
    output logic       ready1,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       grant,
    output logic       busy,
    output logic       err_timeout
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               grant_q, grant_d;
    logic               tx_start_q;
    logic               busy_q;
    logic               win1;
    logic               idle_ok;
    logic               accept;
    logic               err_timeout_d;

    // Arbitration: win1 selects requester 1 as the winner of this cycle.
`ifdef UART_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On a tie the requester not granted last wins; otherwise whoever asks.
    always_comb begin
        win1 = valid1;
        if (valid0 && valid1) begin
            win1 = ~last_grant_q;
        end
    end

    // Updated on every accept, including frames later aborted by timeout.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = win1;
        end
    end

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle.
    always_comb begin
        win1 = valid1 & ~valid0;
    end
`endif

    // Ready is combinational so the winner is accepted in the same IDLE cycle.
    // It is gated by rst so both readies show their reset value during reset.
    assign idle_ok = (state_q == ST_IDLE) && !rst;
    assign ready0  = idle_ok & valid0 & ~win1;
    assign ready1  = idle_ok & valid1 & win1;
    assign accept  = ready0 | ready1;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and datapath logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        grant_d       = grant_q;
        err_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_data_d = win1 ? data1 : data0;
                    grant_d   = win1;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    // Counter saturates at the limit because the frame aborts there.
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            grant_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            tx_start_q <= (state_d == ST_START);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

    // Abort pulse is only known in the cycle tx_busy is still seen low at the
    // limit. A busy arriving in that same cycle must still win, so this
    // output is decoded from the current state and count rather than registered.
    assign err_timeout = err_timeout_d;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. The stimulus pushes the expected
// {grant, byte} of every frame into a scoreboard queue. A monitor pops the
// queue on each tx_start and compares. A simple transmitter model answers
// tx_start with a busy window of configurable length, or never answers.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int unsigned TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid0;
    logic [7:0] data0;
    logic       ready0;
    logic       valid1;
    logic [7:0] data1;
    logic       ready1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       grant;
    logic       busy;
    logic       err_timeout;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];
    int         tx_busy_len   = 3;
    logic       tx_never_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.BUSY_TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid0      (valid0),
        .data0       (data0),
        .ready0      (ready0),
        .valid1      (valid1),
        .data1       (data1),
        .ready1      (ready1),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Waits until busy drops; n is the number of falling edges waited.
    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    // Transmitter model: busy for tx_busy_len cycles starting the cycle after tx_start.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !tx_never_busy) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (tx_busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on every start, no ready while busy.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                check("no_ready_while_busy", 32'({ready0, ready1}), 32'd0);
            end
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_start: got tx_data 0x%0h grant %0d, required no frame",
                             tx_data, grant);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("sb_tx_data", 32'(tx_data), 32'(e[7:0]));
                    check("sb_grant", 32'(grant), 32'(e[8]));
                    check("sb_busy_at_start", 32'(busy), 32'd1);
                end
            end
        end
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int acc;
        int starts;
        int guard;
        int last;
        logic r1_seen;

        rst    = 1'b1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0  = 8'h00;
        data1  = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 32'(ready0), 32'd0);
        check("rst_ready1", 32'(ready1), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single byte from requester 0
        tx_busy_len = 3;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 8'h41});
        valid0 = 1'b1;
        data0  = 8'h41;
        @(negedge clk);
        check("t1_ready0", 32'(ready0), 32'd1);
        check("t1_ready1", 32'(ready1), 32'd0);
        @(posedge clk);
        #1 valid0 = 1'b0;
        @(negedge clk);
        check("t1_tx_start", 32'(tx_start), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'h41);
        check("t1_grant", 32'(grant), 32'd0);
        wait_idle(n);
        check("t1_idle_latency", 32'(n), 32'd5);
        check("t1_tx_data_hold", 32'(tx_data), 32'h41);

        // Single byte from requester 1
        @(posedge clk);
        #1;
        exp_q.push_back({1'b1, 8'h5A});
        valid1 = 1'b1;
        data1  = 8'h5A;
        @(negedge clk);
        check("t1b_ready1", 32'(ready1), 32'd1);
        check("t1b_ready0", 32'(ready0), 32'd0);
        @(posedge clk);
        #1 valid1 = 1'b0;
        @(negedge clk);
        check("t1b_tx_start", 32'(tx_start), 32'd1);
        check("t1b_grant", 32'(grant), 32'd1);
        wait_idle(n);
        check("t1b_idle_latency", 32'(n), 32'd5);

        // Tie, four bytes, shortest busy window
        tx_busy_len = 1;
        @(posedge clk);
        #1;
`ifdef UART_ARB_RR_EN
        exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b1, 8'hB1});
        exp_q.push_back({1'b0, 8'hA0});
        exp_q.push_back({1'b1, 8'hB1});
`else
        repeat (4) exp_q.push_back({1'b0, 8'hA0});
`endif
        valid0 = 1'b1;
        data0  = 8'hA0;
        valid1 = 1'b1;
        data1  = 8'hB1;
        acc     = 0;
        guard   = 0;
        last    = 0;
        r1_seen = 1'b0;
        while (acc < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (ready1) r1_seen = 1'b1;
            if ((valid0 && ready0) || (valid1 && ready1)) begin
                if (acc > 0) check("t2_min_spacing", 32'(guard - last), 32'd4);
                last = guard;
                acc++;
            end
        end
        check("t2_accepts", 32'(acc), 32'd4);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        wait_idle(n);
`ifdef UART_ARB_RR_EN
        check("t2_ready1_seen", 32'(r1_seen), 32'd1);
`else
        check("t2_ready1_never", 32'(r1_seen), 32'd0);
`endif

        // Watchdog timeout with a second byte pending
        tx_never_busy = 1'b1;
        tx_busy_len   = 3;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 8'h33});
        valid0 = 1'b1;
        data0  = 8'h33;
        @(negedge clk);
        check("t3_ready0", 32'(ready0), 32'd1);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        exp_q.push_back({1'b1, 8'h44});
        valid1 = 1'b1;
        data1  = 8'h44;
        @(negedge clk);
        check("t3_tx_start", 32'(tx_start), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 300);
        check("t3_err_delay", 32'(n), 32'(TIMEOUT));
        check("t3_err_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t3_idle_after_err", 32'(busy), 32'd0);
        check("t3_err_one_cycle", 32'(err_timeout), 32'd0);
        check("t3_pending_ready1", 32'(ready1), 32'd1);
        @(posedge clk);
        #1;
        valid1        = 1'b0;
        tx_never_busy = 1'b0;
        @(negedge clk);
        check("t3_next_start", 32'(tx_start), 32'd1);
        check("t3_next_grant", 32'(grant), 32'd1);
        wait_idle(n);
        check("t3_next_idle_latency", 32'(n), 32'd5);

        // Reset asserted in WAIT_DONE
        tx_busy_len = 8;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b1, 8'h77});
        valid1 = 1'b1;
        data1  = 8'h77;
        @(negedge clk);
        check("t4_ready1", 32'(ready1), 32'd1);
        @(posedge clk);
        #1 valid1 = 1'b0;
        @(negedge clk);
        check("t4_tx_start", 32'(tx_start), 32'd1);
        repeat (3) @(negedge clk);
        check("t4_in_flight_busy", 32'(busy), 32'd1);
        check("t4_in_flight_tx_busy", 32'(tx_busy), 32'd1);
        #2;
        rst    = 1'b1;
        valid1 = 1'b1;
        data1  = 8'h66;
        #1;
        check("t4_async_ready0", 32'(ready0), 32'd0);
        check("t4_async_ready1", 32'(ready1), 32'd0);
        check("t4_async_tx_start", 32'(tx_start), 32'd0);
        check("t4_async_tx_data", 32'(tx_data), 32'h00);
        check("t4_async_grant", 32'(grant), 32'd0);
        check("t4_async_busy", 32'(busy), 32'd0);
        check("t4_async_err", 32'(err_timeout), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        exp_q.push_back({1'b1, 8'h66});
        rst = 1'b0;
        @(negedge clk);
        check("t4_post_rst_ready1", 32'(ready1), 32'd1);
        check("t4_post_rst_ready0", 32'(ready0), 32'd0);
        @(posedge clk);
        #1 valid1 = 1'b0;
        @(negedge clk);
        check("t4_post_rst_start", 32'(tx_start), 32'd1);
        check("t4_post_rst_grant", 32'(grant), 32'd1);
        wait_idle(n);
        check("t4_idle_latency", 32'(n), 32'd10);

        // Back-to-back from requester 1 with a long busy window
        tx_busy_len = 10;
        @(posedge clk);
        #1;
        repeat (3) exp_q.push_back({1'b1, 8'hC3});
        valid1 = 1'b1;
        data1  = 8'hC3;
        acc    = 0;
        starts = 0;
        guard  = 0;
        last   = 0;
        while (acc < 3 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (tx_start) starts++;
            if (valid1 && ready1) begin
                if (acc > 0) check("t5_spacing", 32'(guard - last), 32'd13);
                last = guard;
                acc++;
            end
        end
        check("t5_accepts", 32'(acc), 32'd3);
        @(posedge clk);
        #1 valid1 = 1'b0;
        @(negedge clk);
        if (tx_start) starts++;
        check("t5_starts", 32'(starts), 32'd3);
        wait_idle(n);
        check("t5_idle_latency", 32'(n), 32'd12);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
